// File: rtl/wb_tg_pkg.sv
// Shared Wishbone traffic-generator types: cycle/burst type codes and FSM states.
package wb_tg_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   typedef enum logic [2:0] {
      IDLE,
      WR_BURST,
      WR_GAP,
      RD_BURST,
      RD_GAP,
      DONE
   } tg_state_e;

endpackage

// File: rtl/wb_tg_pattern.sv
// Address-derived test pattern: (zero-extended address ^ seed), replicated/truncated
// to DW, rotated left by (address mod DW).
module wb_tg_pattern #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 30
) (
   input  logic [AW-1:0] adr,
   input  logic [31:0]   seed,
   output logic [DW-1:0] pat_c
);

   localparam int unsigned XW  = (AW > 32) ? AW : 32;
   localparam int unsigned REP = (DW + XW - 1) / XW;
   localparam int unsigned RW  = $clog2(DW);

   logic [XW-1:0]     word;
   logic [REP*XW-1:0] rep;
   logic [DW-1:0]     base;
   logic [RW-1:0]     rot;

   always_comb begin
      word  = XW'(adr) ^ XW'(seed);
      rep   = {REP{word}};
      base  = rep[DW-1:0];
      rot   = RW'(XW'(adr) % XW'(DW));
      // a shift by the full width yields zero, so rot == 0 needs no special case
      pat_c = (base << rot) | (base >> (DW - 32'(rot)));
   end

endmodule

// File: rtl/wb_traffic_gen.sv
// Wishbone burst traffic generator: writes a pattern over NUM_BURSTS bursts, reads it back
// and checks it. Define WB_TG_TIMEOUT_EN to add the no-ack watchdog.
module wb_traffic_gen
   import wb_tg_pkg::*;
#(
   parameter int unsigned    DW         = 32,
   parameter int unsigned    AW         = 30,
   parameter int unsigned    BURST_LEN  = 4,
   parameter int unsigned    NUM_BURSTS = 16,
   parameter logic [AW-1:0]  BASE_ADR   = '0,
   parameter logic [31:0]    SEED       = 32'hA5A5_0F0F,
   parameter int unsigned    TIMEOUT    = 1024
) (
   input  logic            wb_clk,
   input  logic            wb_rst_n,
   input  logic            start,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic [2:0]      wb_cti_o,
   output logic [1:0]      wb_bte_o,
   output logic            wb_we_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic            wb_ack_i,
   output logic            busy,
   output logic            done,
   output logic            ok,
   output logic [15:0]     err_cnt,
   output logic [AW-1:0]   err_adr,
   output logic            timeout
);

   localparam int unsigned BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned NBW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

   if ((DW % 8 != 0) || (BURST_LEN != 1 && BURST_LEN != 4 && BURST_LEN != 8 && BURST_LEN != 16)
       || NUM_BURSTS == 0 || TIMEOUT == 0) begin : g_bad_cfg
      $error("wb_traffic_gen: illegal parameter set");
   end

   tg_state_e       state_q, state_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [BCW-1:0]  beat_q, beat_d;
   logic [NBW-1:0]  burst_q, burst_d;
   logic            cyc_q, cyc_d;
   logic            we_q, we_d;
   logic [2:0]      cti_q, cti_d;
   logic [DW-1:0]   dat_q, dat_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ok_q, ok_d;
   logic [15:0]     err_cnt_q, err_cnt_d;
   logic [AW-1:0]   err_adr_q, err_adr_d;
   logic [DW-1:0]   pat_wr, pat_rd;
   logic            ack_v, last_beat, last_burst;

`ifdef WB_TG_TIMEOUT_EN
   localparam int unsigned WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0]  wdog_q, wdog_d;
   logic            tmo_q, tmo_d;
`endif

   // write data is registered from the next address; the read check uses the live one
   wb_tg_pattern #(.DW(DW), .AW(AW)) u_pat_wr (.adr(adr_d), .seed(SEED), .pat_c(pat_wr));
   wb_tg_pattern #(.DW(DW), .AW(AW)) u_pat_rd (.adr(adr_q), .seed(SEED), .pat_c(pat_rd));

   assign ack_v      = wb_ack_i & cyc_q;
   assign last_beat  = (beat_q == BCW'(BURST_LEN - 1));
   assign last_burst = (burst_q == NBW'(NUM_BURSTS - 1));

   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      beat_d    = beat_q;
      burst_d   = burst_q;
      done_d    = done_q;
      ok_d      = ok_q;
      err_cnt_d = err_cnt_q;
      err_adr_d = err_adr_q;
`ifdef WB_TG_TIMEOUT_EN
      wdog_d    = '0;
      tmo_d     = tmo_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = WR_BURST;
               adr_d     = BASE_ADR;
               beat_d    = '0;
               burst_d   = '0;
               done_d    = 1'b0;
               ok_d      = 1'b0;
               err_cnt_d = '0;
               err_adr_d = '0;
`ifdef WB_TG_TIMEOUT_EN
               tmo_d     = 1'b0;
`endif
            end
         end
         WR_BURST, RD_BURST: begin
            if (ack_v) begin
               adr_d  = adr_q + AW'(1);
               beat_d = beat_q + BCW'(1);
               if (state_q == RD_BURST && wb_dat_i != pat_rd) begin
                  if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                  if (err_cnt_q == 16'd0)    err_adr_d = adr_q;
               end
               if (last_beat) begin
                  beat_d  = '0;
                  burst_d = last_burst ? '0 : burst_q + NBW'(1);
                  if (state_q == WR_BURST) begin
                     state_d = WR_GAP;
                     if (last_burst) adr_d = BASE_ADR;
                  end else if (last_burst) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                     ok_d    = (err_cnt_d == 16'd0);
                  end else begin
                     state_d = RD_GAP;
                  end
               end
            end
`ifdef WB_TG_TIMEOUT_EN
            else begin
               wdog_d = wdog_q + WDW'(1);
               if (wdog_d == WDW'(TIMEOUT)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  ok_d    = 1'b0;
                  tmo_d   = 1'b1;
               end
            end
`endif
         end
         // burst counter wraps to zero only once the whole write phase is complete
         WR_GAP:  state_d = (burst_q == '0) ? RD_BURST : WR_BURST;
         RD_GAP:  state_d = RD_BURST;
         default: state_d = IDLE;
      endcase

      cyc_d  = (state_d == WR_BURST) || (state_d == RD_BURST);
      we_d   = (state_d == WR_BURST);
      busy_d = (state_d != IDLE) && (state_d != DONE);
      dat_d  = (state_d == WR_BURST) ? pat_wr : '0;
      cti_d  = CTI_CLASSIC;
      if (cyc_d && BURST_LEN > 1)
         cti_d = (beat_d == BCW'(BURST_LEN - 1)) ? CTI_EOB : CTI_INC;
   end

   always_ff @(posedge wb_clk) begin
      if (!wb_rst_n) begin
         state_q   <= IDLE;
         adr_q     <= '0;
         beat_q    <= '0;
         burst_q   <= '0;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         cti_q     <= CTI_CLASSIC;
         dat_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ok_q      <= 1'b0;
         err_cnt_q <= '0;
         err_adr_q <= '0;
`ifdef WB_TG_TIMEOUT_EN
         wdog_q    <= '0;
         tmo_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         adr_q     <= adr_d;
         beat_q    <= beat_d;
         burst_q   <= burst_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         cti_q     <= cti_d;
         dat_q     <= dat_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ok_q      <= ok_d;
         err_cnt_q <= err_cnt_d;
         err_adr_q <= err_adr_d;
`ifdef WB_TG_TIMEOUT_EN
         wdog_q    <= wdog_d;
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = '1;
   assign wb_cti_o = cti_q;
   assign wb_bte_o = BTE_LINEAR;
   assign wb_we_o  = we_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign ok       = ok_q;
   assign err_cnt  = err_cnt_q;
   assign err_adr  = err_adr_q;
`ifdef WB_TG_TIMEOUT_EN
   assign timeout  = tmo_q;
`else
   assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_traffic_gen.sv
// Bench for wb_traffic_gen: three instances (default, address wrap, single-beat) driven by a
// memory-backed slave model; expected beats are queued at start and popped on each ack.
module tb_wb_traffic_gen;

   localparam int unsigned NI      = 3;
   localparam logic [31:0] SEED_TB = 32'hA5A5_0F0F;

   logic        clk;
   logic        rst_n;
   logic        start   [NI];
   logic [29:0] adr     [NI];
   logic [31:0] dat_o   [NI];
   logic [3:0]  sel     [NI];
   logic [2:0]  cti     [NI];
   logic [1:0]  bte     [NI];
   logic        we      [NI];
   logic        cyc     [NI];
   logic        stb     [NI];
   logic [31:0] dat_i   [NI];
   logic        ack     [NI];
   logic        busy    [NI];
   logic        done    [NI];
   logic        ok      [NI];
   logic [15:0] err_cnt [NI];
   logic [29:0] err_adr [NI];
   logic        tmo     [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      wb_traffic_gen #(
         .DW         (32),
         .AW         (30),
         .BURST_LEN  ((g == 2) ? 1 : 4),
         .NUM_BURSTS ((g == 0) ? 16 : ((g == 1) ? 1 : 8)),
         .BASE_ADR   ((g == 1) ? 30'h3FFF_FFFE : 30'd0),
         .SEED       (SEED_TB),
         .TIMEOUT    ((g == 2) ? 16 : 1024)
      ) u_dut (
         .wb_clk   (clk),
         .wb_rst_n (rst_n),
         .start    (start[g]),
         .wb_adr_o (adr[g]),
         .wb_dat_o (dat_o[g]),
         .wb_sel_o (sel[g]),
         .wb_cti_o (cti[g]),
         .wb_bte_o (bte[g]),
         .wb_we_o  (we[g]),
         .wb_cyc_o (cyc[g]),
         .wb_stb_o (stb[g]),
         .wb_dat_i (dat_i[g]),
         .wb_ack_i (ack[g]),
         .busy     (busy[g]),
         .done     (done[g]),
         .ok       (ok[g]),
         .err_cnt  (err_cnt[g]),
         .err_adr  (err_adr[g]),
         .timeout  (tmo[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          inst;
      int          waits;
      logic [29:0] cadr;
      int          ccnt;
      int          exp_err;
      logic [29:0] exp_eadr;
      bit          exp_ok;
   } vec_t;

   typedef struct {
      logic [29:0] adr;
      logic        we;
      logic [2:0]  cti;
      logic [31:0] dat;
      bit          last_b;
      bit          last_all;
   } beat_t;

   beat_t       exp_q [$];
   logic [31:0] mem [logic [29:0]];
   vec_t        vecs [7];
   int          n_vec = 0;
   int          n_err = 0;

   function automatic int bl_of(int i);
      return (i == 2) ? 1 : 4;
   endfunction

   function automatic int nb_of(int i);
      return (i == 0) ? 16 : ((i == 1) ? 1 : 8);
   endfunction

   function automatic logic [29:0] base_of(int i);
      return (i == 1) ? 30'h3FFF_FFFE : 30'd0;
   endfunction

   // DW == 32 reference: rotate the seeded address by its low five bits
   function automatic logic [31:0] pat(logic [29:0] a);
      logic [31:0] w;
      int          r;
      w = {2'b00, a} ^ SEED_TB;
      r = int'(a[4:0]);
      return (r == 0) ? w : ((w << r) | (w >> (32 - r)));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int          i, bl, nb, wcnt, gap, cyc_n;
      logic [29:0] base, a;
      logic [31:0] rd;
      beat_t       e;
      i    = v.inst;
      bl   = bl_of(i);
      nb   = nb_of(i);
      base = base_of(i);
      exp_q.delete();
      mem.delete();
      for (int ph = 0; ph < 2; ph++)
         for (int b = 0; b < nb; b++)
            for (int k = 0; k < bl; k++) begin
               a          = base + 30'(b * bl + k);
               e.adr      = a;
               e.we       = (ph == 0);
               e.cti      = (bl == 1) ? 3'b000 : ((k == bl - 1) ? 3'b111 : 3'b010);
               e.dat      = pat(a);
               e.last_b   = (k == bl - 1);
               e.last_all = (ph == 1) && (b == nb - 1) && (k == bl - 1);
               exp_q.push_back(e);
            end
      chk("idle_cyc", cyc[i], 0);
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      chk("start_cyc", cyc[i], 1);
      chk("start_busy", busy[i], 1);
      chk("start_done_clr", done[i], 0);
      wcnt  = 0;
      gap   = 0;
      cyc_n = 0;
      while (exp_q.size() != 0 && cyc_n < 4000) begin
         start[i] = (cyc_n == 10);
         ack[i]   = !cyc[i];
         dat_i[i] = '0;
         if (gap != 0) begin
            chk("gap_cyc", cyc[i], (gap == 2) ? 0 : 1);
            gap--;
         end
         if (cyc[i] && stb[i]) begin
            if (wcnt < v.waits) wcnt++;
            else begin
               wcnt   = 0;
               ack[i] = 1'b1;
               e      = exp_q.pop_front();
               chk("beat_adr", adr[i], e.adr);
               chk("beat_we", we[i], e.we);
               chk("beat_cti", cti[i], e.cti);
               chk("beat_sel_bte", {sel[i], bte[i]}, 6'b111100);
               if (e.we) begin
                  chk("wr_dat", dat_o[i], e.dat);
                  mem[e.adr] = dat_o[i];
               end else begin
                  rd = mem.exists(e.adr) ? mem[e.adr] : 32'h0;
                  if (30'(e.adr - v.cadr) < 30'(v.ccnt)) rd[0] = ~rd[0];
                  dat_i[i] = rd;
               end
               if (e.last_b && !e.last_all) gap = 2;
            end
         end
         @(negedge clk);
         cyc_n++;
      end
      start[i] = 1'b0;
      ack[i]   = 1'b0;
      chk("beats_remaining", exp_q.size(), 0);
      chk("end_done", done[i], 1);
      chk("end_ok", ok[i], v.exp_ok);
      chk("end_err_cnt", err_cnt[i], v.exp_err);
      chk("end_err_adr", err_adr[i], v.exp_eadr);
      chk("end_busy", busy[i], 0);
      chk("end_cyc", cyc[i], 0);
      chk("end_timeout", tmo[i], 0);
      @(negedge clk);
      chk("done_sticky", done[i], 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: got run still active, expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      vecs[0] = '{0, 0, 30'd0,          0, 0, 30'd0,          1'b1};
      vecs[1] = '{0, 0, 30'd5,          1, 1, 30'd5,          1'b0};
      vecs[2] = '{0, 2, 30'd9,          3, 3, 30'd9,          1'b0};
      vecs[3] = '{0, 1, 30'd0,          0, 0, 30'd0,          1'b1};
      vecs[4] = '{1, 0, 30'd0,          0, 0, 30'd0,          1'b1};
      vecs[5] = '{1, 0, 30'h3FFF_FFFF,  1, 1, 30'h3FFF_FFFF,  1'b0};
      vecs[6] = '{2, 3, 30'd0,          0, 0, 30'd0,          1'b1};

      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         start[i] = 1'b0;
         ack[i]   = 1'b0;
         dat_i[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk("rst_cyc_stb_we", {cyc[i], stb[i], we[i]}, 0);
         chk("rst_adr", adr[i], 0);
         chk("rst_dat", dat_o[i], 0);
         chk("rst_cti", cti[i], 0);
         chk("rst_sel_bte", {sel[i], bte[i]}, 6'b111100);
         chk("rst_status", {busy[i], done[i], ok[i], tmo[i]}, 0);
         chk("rst_err", {err_cnt[i], err_adr[i]}, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 7; n++) run_vec(vecs[n]);

      // reset asserted while the third write beat is on the bus
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ack[0] = 1'b1;
         @(negedge clk);
      end
      chk("mid_rst_beat3_adr", adr[0], 2);
      chk("mid_rst_beat3_cyc", cyc[0], 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_cyc_stb", {cyc[0], stb[0]}, 0);
      chk("mid_rst_busy_done", {busy[0], done[0]}, 0);
      chk("mid_rst_adr_cti", {adr[0], cti[0]}, 0);
      rst_n  = 1'b1;
      ack[0] = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", {cyc[0], busy[0]}, 0);

`ifdef WB_TG_TIMEOUT_EN
      begin
         int n;
         n        = 0;
         start[2] = 1'b1;
         @(negedge clk);
         start[2] = 1'b0;
         while (!done[2] && n < 100) begin
            if (cyc[2]) n++;
            @(negedge clk);
         end
         chk("tmo_cyc_cycles", n, 16);
         chk("tmo_flag", tmo[2], 1);
         chk("tmo_done", done[2], 1);
         chk("tmo_ok", ok[2], 0);
         chk("tmo_cyc", cyc[2], 0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
